// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline-control definitions: wait-FSM encoding, register-zero id,
// counter width and the hazard classification used by the priority logic.
package hazard_detection_unit_pkg;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int         CNT_W    = 16;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_LOAD_USE,
        HZ_BRANCH,
        HZ_MEM_STALL
    } hazardKind_t;

endpackage

// File: rtl/hazard_detection_unit_mem_wait_timer.sv
// Counts cycles spent waiting on data memory and raises a sticky timeout
// once the wait has lasted TIMEOUT_LIMIT cycles with the stall still active.
module mem_wait_timer #(
    parameter int TIMEOUT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enterWait,
    input  logic inWait,
    input  logic leaveWait,
    input  logic memStall,
    output logic MemTimeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_LIMIT);

    logic [7:0] WaitCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            WaitCnt    <= 8'd0;
            MemTimeout <= 1'b0;
        end else begin
            if (enterWait) begin
                WaitCnt <= 8'd1;
            end else if (leaveWait) begin
                WaitCnt <= 8'd0;
            end else if (inWait && memStall && WaitCnt != 8'hFF) begin
                // Holding at all-ones keeps a very long wait from wrapping.
                WaitCnt <= WaitCnt + 8'd1;
            end
            if (memStall && WaitCnt == LIMIT) begin
                MemTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard control: same-cycle stall/flush decisions with priority
// memory-stall > taken-branch > load-use, plus a memory-wait FSM and counters.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int TIMEOUT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_E,
    input  logic [4:0]       DestinationReg_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             UsesRs1_D,
    input  logic             UsesRs2_D,
    input  logic             BranchTaken_E,
    input  logic             DMemReq_M,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MEMWBBubble,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic             FsmState
);

    logic [0:0]  state;
    logic [0:0]  stateNext;
    logic        memStall;
    logic        loadUse;
    hazardKind_t hazardKind;

    assign memStall = DMemReq_M & ~DMemReady;
    assign loadUse  = MemRead_E & (DestinationReg_E != ZERO_REG) &
                      ((UsesRs1_D & (Rs1_D == DestinationReg_E)) |
                       (UsesRs2_D & (Rs2_D == DestinationReg_E)));

    always_comb begin
        hazardKind = HZ_NONE;
        if (memStall) begin
            hazardKind = HZ_MEM_STALL;
        end else if (BranchTaken_E) begin
            hazardKind = HZ_BRANCH;
        end else if (loadUse) begin
            hazardKind = HZ_LOAD_USE;
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        MEMWBBubble = 1'b0;
        if (reset) begin
            // Keep every stage clocking while injecting NOPs so the pipe drains.
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            MEMWBBubble = 1'b1;
        end else begin
            case (hazardKind)
                HZ_MEM_STALL: begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMWrite  = 1'b0;
                    MEMWBBubble = 1'b1;
                end
                HZ_BRANCH: begin
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end
                HZ_LOAD_USE: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:      if (memStall)  stateNext = MEM_WAIT;
            MEM_WAIT: if (DMemReady) stateNext = RUN;
            default:  stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    assign FsmState = state[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!PCWrite && StallCycles != '1) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (IFIDFlush && FlushCount != '1) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

    mem_wait_timer #(
        .TIMEOUT_LIMIT(TIMEOUT_LIMIT)
    ) u_mem_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .enterWait  ((state == RUN) && memStall),
        .inWait     (state == MEM_WAIT),
        .leaveWait  ((state == MEM_WAIT) && DMemReady),
        .memStall   (memStall),
        .MemTimeout (MemTimeout)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a behavioural model.
module tb_hazard_detection_unit;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_E;
    logic [4:0]  DestinationReg_E;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic        UsesRs1_D;
    logic        UsesRs2_D;
    logic        BranchTaken_E;
    logic        DMemReq_M;
    logic        DMemReady;
    logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
    logic        IFIDFlush, IDEXFlush, MEMWBBubble, MemTimeout;
    logic [15:0] StallCycles, FlushCount;
    logic        FsmState;

    int check_count = 0;
    int pass_count  = 0;
    bit cmp_en      = 1'b0;

    // model state
    bit m_wait;
    int m_cnt;
    bit m_timeout;
    int m_stall;
    int m_flush;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    hazard_detection_unit #(
        .TIMEOUT_LIMIT(LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .MemRead_E        (MemRead_E),
        .DestinationReg_E (DestinationReg_E),
        .Rs1_D            (Rs1_D),
        .Rs2_D            (Rs2_D),
        .UsesRs1_D        (UsesRs1_D),
        .UsesRs2_D        (UsesRs2_D),
        .BranchTaken_E    (BranchTaken_E),
        .DMemReq_M        (DMemReq_M),
        .DMemReady        (DMemReady),
        .PCWrite          (PCWrite),
        .IFIDWrite        (IFIDWrite),
        .IDEXWrite        (IDEXWrite),
        .EXMEMWrite       (EXMEMWrite),
        .IFIDFlush        (IFIDFlush),
        .IDEXFlush        (IDEXFlush),
        .MEMWBBubble      (MEMWBBubble),
        .MemTimeout       (MemTimeout),
        .StallCycles      (StallCycles),
        .FlushCount       (FlushCount),
        .FsmState         (FsmState)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // Returns {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXFlush,MEMWBBubble}.
    function automatic logic [6:0] model_ctrl();
        bit stall_mem, lu;
        stall_mem = DMemReq_M && !DMemReady;
        lu = MemRead_E && DestinationReg_E != 0 &&
             ((UsesRs1_D && Rs1_D == DestinationReg_E) ||
              (UsesRs2_D && Rs2_D == DestinationReg_E));
        if (reset)              return 7'b1111_111;
        else if (stall_mem)     return 7'b0000_001;
        else if (BranchTaken_E) return 7'b1111_110;
        else if (lu)            return 7'b0011_010;
        else                    return 7'b1111_000;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        bit stall_mem;
        c = model_ctrl();
        stall_mem = DMemReq_M && !DMemReady;
        if (reset) begin
            m_wait = 0; m_cnt = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!c[6] && m_stall < 65535) m_stall++;
            if (c[2] && m_flush < 65535) m_flush++;
            if (stall_mem) begin
                if (m_wait && m_cnt == LIMIT) m_timeout = 1;
                if (!m_wait) begin
                    m_wait = 1;
                    m_cnt  = 1;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
            end else if (m_wait && DMemReady) begin
                m_wait = 0;
                m_cnt  = 0;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctrl", {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                           IFIDFlush, IDEXFlush, MEMWBBubble}, model_ctrl());
            check("timeout", MemTimeout, m_timeout);
            check("stall_cnt", StallCycles, m_stall);
            check("flush_cnt", FlushCount, m_flush);
            check("state", FsmState, m_wait);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input bit u1, input bit u2,
                         input bit br, input bit req, input bit rdy);
        MemRead_E = mr; DestinationReg_E = rd; Rs1_D = r1; Rs2_D = r2;
        UsesRs1_D = u1; UsesRs2_D = u2; BranchTaken_E = br;
        DMemReq_M = req; DMemReady = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("rst_pcwrite", PCWrite, 1'b1);
        check("rst_ifidflush", IFIDFlush, 1'b1);
        check("rst_bubble", MEMWBBubble, 1'b1);
        next_cycle();
        cmp_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        check("rst_stallcnt", StallCycles, 16'd0);
        check("rst_flushcnt", FlushCount, 16'd0);
        check("rst_state", FsmState, 1'b0);

        // load-use on x5 through Rs1
        next_cycle();
        drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("lu_pcwrite", PCWrite, 1'b0);
        check("lu_ifidwrite", IFIDWrite, 1'b0);
        check("lu_idexflush", IDEXFlush, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("lu_stallcnt", StallCycles, 16'd1);

        // register zero and unused Rs1 never hazard
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("x0_pcwrite", PCWrite, 1'b1);
        next_cycle();
        drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("nouse_pcwrite", PCWrite, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("nohz_stallcnt", StallCycles, 16'd0);

        // branch outranks load-use
        do_reset();
        drive(1, 5, 5, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        check("br_ifidflush", IFIDFlush, 1'b1);
        check("br_idexflush", IDEXFlush, 1'b1);
        check("br_pcwrite", PCWrite, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("br_flushcnt", FlushCount, 16'd1);
        check("br_stallcnt", StallCycles, 16'd0);

        // three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            check("mw_bubble", MEMWBBubble, 1'b1);
            check("mw_pcwrite", PCWrite, 1'b0);
            next_cycle();
            check("mw_state_wait", FsmState, 1'b1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        check("mw_release_pcwrite", PCWrite, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("mw_state_run", FsmState, 1'b0);
        check("mw_stallcnt", StallCycles, 16'd3);

        // timeout after LIMIT cycles in the wait state
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= LIMIT + 3; i++) begin
            next_cycle();
            if (i == LIMIT) check("to_not_yet", MemTimeout, 1'b0);
            if (i >= LIMIT + 1) check("to_set", MemTimeout, 1'b1);
        end
        check("to_state", FsmState, 1'b1);
        check("to_pcwrite", PCWrite, 1'b0);
        do_reset();
        check("to_cleared", MemTimeout, 1'b0);
        check("to_state_run", FsmState, 1'b0);

        // branch held during a two-cycle wait flushes on release
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
            @(negedge clk);
            check("bw_no_flush", IFIDFlush, 1'b0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        check("bw_ifidflush", IFIDFlush, 1'b1);
        check("bw_idexflush", IDEXFlush, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("bw_flushcnt", FlushCount, 16'd1);
        check("bw_stallcnt", StallCycles, 16'd2);

        // random traffic, model checked every cycle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                  (i < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1));
            next_cycle();
        end
        reset = 1'b0;
        idle();
        next_cycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
